// File: rtl/thread_issue_scheduler.sv
// Round-robin fetch-issue scheduler: picks one eligible hardware thread per cycle
// and offers it to fetch through a valid/ready handshake, with per-thread stall counters.
module thread_issue_scheduler #(
  parameter int THREAD_INDEX_BITS  = 3,
  parameter int BLOCK_CYCLES_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [(1<<THREAD_INDEX_BITS)-1:0]   in_thread_enable_mask,
  input  logic                                in_block_valid,
  input  logic [THREAD_INDEX_BITS-1:0]        in_block_thread_index,
  input  logic [BLOCK_CYCLES_WIDTH-1:0]       in_block_cycles,
  input  logic                                in_fetch_ready,
  output logic                                out_issue_valid,
  output logic [THREAD_INDEX_BITS-1:0]        out_thread_index,
  output logic                                out_increment_flag
);

  localparam int N = 1 << THREAD_INDEX_BITS;

  logic [N-1:0]                 eligible;
  logic [N-1:0]                 block_load;
  logic                         issue_valid_reg;
  logic [THREAD_INDEX_BITS-1:0] thread_index_reg;
  logic [THREAD_INDEX_BITS-1:0] last_grant_reg;
  logic                         hit_found;
  logic [THREAD_INDEX_BITS-1:0] hit_index;
  logic                         fire;
  logic                         load_en;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_thread
      logic [BLOCK_CYCLES_WIDTH-1:0] cnt_reg;

      // A thread being blocked this very cycle is already ineligible.
      assign block_load[gi] = in_block_valid
                            && (in_block_thread_index == THREAD_INDEX_BITS'(gi))
                            && (in_block_cycles != '0);

      assign eligible[gi] = in_thread_enable_mask[gi] & (cnt_reg == '0) & ~block_load[gi];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (block_load[gi]) begin
          cnt_reg <= in_block_cycles;
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - BLOCK_CYCLES_WIDTH'(1);
        end
      end
    end
  endgenerate

  // Search starts just after the last grant and checks the last grant itself last.
  always_comb begin
    logic [THREAD_INDEX_BITS-1:0] cand;
    hit_found = 1'b0;
    hit_index = last_grant_reg;
    cand      = last_grant_reg;
    for (int k = 1; k <= N; k++) begin
      cand = last_grant_reg + THREAD_INDEX_BITS'(k);
      if (!hit_found && eligible[cand]) begin
        hit_found = 1'b1;
        hit_index = cand;
      end
    end
  end

  assign fire    = issue_valid_reg & in_fetch_ready;
  assign load_en = !issue_valid_reg || fire;

  // A held offer is never withdrawn; it only changes once it fires or was empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_reg  <= 1'b0;
      thread_index_reg <= '0;
      last_grant_reg   <= '1;
    end else if (load_en) begin
      if (hit_found) begin
        issue_valid_reg  <= 1'b1;
        thread_index_reg <= hit_index;
        last_grant_reg   <= hit_index;
      end else begin
        issue_valid_reg  <= 1'b0;
      end
    end
  end

  assign out_issue_valid    = issue_valid_reg;
  assign out_thread_index   = thread_index_reg;
  assign out_increment_flag = fire;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Directed bench for thread_issue_scheduler: inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_thread_issue_scheduler;
  localparam int TIB = 3;
  localparam int BCW = 4;
  localparam int N   = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   mask;
  logic           block_valid;
  logic [TIB-1:0] block_idx;
  logic [BCW-1:0] block_cycles;
  logic           fetch_ready;
  logic           issue_valid;
  logic [TIB-1:0] thread_index;
  logic           increment_flag;

  int checks = 0;
  int errors = 0;

  thread_issue_scheduler #(
    .THREAD_INDEX_BITS  (TIB),
    .BLOCK_CYCLES_WIDTH (BCW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_thread_enable_mask (mask),
    .in_block_valid        (block_valid),
    .in_block_thread_index (block_idx),
    .in_block_cycles       (block_cycles),
    .in_fetch_ready        (fetch_ready),
    .out_issue_valid       (issue_valid),
    .out_thread_index      (thread_index),
    .out_increment_flag    (increment_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [TIB-1:0] idx, input logic f);
    #1;
    check({tag, ".valid"}, {7'd0, issue_valid}, {7'd0, v});
    check({tag, ".index"}, {5'd0, thread_index}, {5'd0, idx});
    check({tag, ".incr"},  {7'd0, increment_flag}, {7'd0, f});
    $display("cycle t=%0t %s valid=%0b index=%0d incr=%0b", $time, tag, issue_valid, thread_index, increment_flag);
  endtask

  task automatic block(input logic [TIB-1:0] idx, input logic [BCW-1:0] c);
    block_valid  = 1'b1;
    block_idx    = idx;
    block_cycles = c;
  endtask

  task automatic unblock();
    block_valid  = 1'b0;
    block_idx    = '0;
    block_cycles = '0;
  endtask

  initial begin
    reset       = 1'b1;
    mask        = 8'hFF;
    fetch_ready = 1'b1;
    unblock();
    #1 reset = 1'b0;
    expect_out("reset", 1'b0, 3'd0, 1'b0);

    // Reset release: full rotation 0..7,0 at one per cycle.
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      expect_out("rotate", 1'b1, 3'(k - 1), 1'b1);
    end

    // Backpressure while thread 3 is offered.
    @(negedge clk); expect_out("pre_bp", 1'b1, 3'd1, 1'b1);
    @(negedge clk); expect_out("pre_bp", 1'b1, 3'd2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fetch_ready = 1'b0;
      expect_out("hold3", 1'b1, 3'd3, 1'b0);
    end
    @(negedge clk); fetch_ready = 1'b1;
    expect_out("fire3", 1'b1, 3'd3, 1'b1);
    @(negedge clk); mask = 8'b0010_0100;
    expect_out("after3", 1'b1, 3'd4, 1'b1);

    // Two-thread and single-thread masks.
    @(negedge clk); expect_out("mask25", 1'b1, 3'd5, 1'b1);
    @(negedge clk); expect_out("mask25", 1'b1, 3'd2, 1'b1);
    @(negedge clk); expect_out("mask25", 1'b1, 3'd5, 1'b1);
    @(negedge clk); mask = 8'b0000_0100;
    expect_out("mask25", 1'b1, 3'd2, 1'b1);
    @(negedge clk); expect_out("mask2", 1'b1, 3'd2, 1'b1);
    @(negedge clk); mask = 8'hFF;
    expect_out("mask2", 1'b1, 3'd2, 1'b1);

    // All enabled; block thread 1 for 3 cycles just before its turn.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) block(3'd1, 4'd3);
      expect_out("preblk", 1'b1, 3'(k + 3), 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      unblock();
      if (k == 7) mask = 8'b0000_0011;
      expect_out("skip1", 1'b1, 3'(k + 2), 1'b1);
    end

    // Threads 0,1 only: block 1 for 3 cycles, re-offered exactly at t+5.
    @(negedge clk); block(3'd1, 4'd3);
    expect_out("blk_t", 1'b1, 3'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); unblock();
      expect_out("blk_wait", 1'b1, 3'd0, 1'b1);
    end
    @(negedge clk); expect_out("blk_reoffer", 1'b1, 3'd1, 1'b1);
    @(negedge clk); block(3'd1, 4'd0);
    expect_out("blk_zero_t", 1'b1, 3'd0, 1'b1);
    @(negedge clk); unblock(); mask = 8'h00;
    expect_out("blk_zero", 1'b1, 3'd1, 1'b1);

    // No enabled threads, then the only enabled thread blocked.
    @(negedge clk); expect_out("mask0", 1'b0, 3'd1, 1'b0);
    @(negedge clk); mask = 8'b0000_0001; block(3'd0, 4'd5);
    expect_out("mask0", 1'b0, 3'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); unblock();
      expect_out("allblk", 1'b0, 3'd1, 1'b0);
    end
    @(negedge clk); mask = 8'hFF;
    expect_out("allblk_end", 1'b1, 3'd0, 1'b1);

    // Held thread 6 blocked under backpressure still fires.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) mask = 8'b0100_0000;
      expect_out("to6", 1'b1, 3'(k), 1'b1);
    end
    @(negedge clk); fetch_ready = 1'b0; block(3'd6, 4'd2);
    expect_out("held6", 1'b1, 3'd6, 1'b0);
    @(negedge clk); unblock();
    expect_out("held6", 1'b1, 3'd6, 1'b0);
    @(negedge clk); fetch_ready = 1'b1;
    expect_out("fire6", 1'b1, 3'd6, 1'b1);
    @(negedge clk); expect_out("gap6", 1'b0, 3'd6, 1'b0);
    @(negedge clk); expect_out("reissue6", 1'b1, 3'd6, 1'b1);

    // Asynchronous reset mid-stream clears outputs before any edge.
    #1 reset = 1'b0; mask = 8'hFF;
    expect_out("async_rst", 1'b0, 3'd0, 1'b0);
    @(negedge clk); expect_out("in_rst", 1'b0, 3'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk); expect_out("post_rst", 1'b1, 3'd0, 1'b1);
    @(negedge clk); expect_out("post_rst", 1'b1, 3'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/thread_issue_scheduler.md
# thread_issue_scheduler

Round-robin fetch-issue scheduler for the multithreaded front end. Each cycle it picks one eligible hardware thread and drives the per-thread program-counter array's thread-index and increment-flag inputs. It offers the selection to the fetch stage through a valid/ready handshake. Threads can be masked off by software enable, or stalled for a programmed number of cycles by later pipeline stages after branches and loads.

## Interface
- THREAD_INDEX_BITS, 3, log2 of thread count; N = 2**THREAD_INDEX_BITS
- BLOCK_CYCLES_WIDTH, 4, width of per-thread stall counters
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- in_thread_enable_mask  in  N  bit i = 1: thread i may be issued
- in_block_valid  in  1  load a stall count for one thread this cycle
- in_block_thread_index  in  THREAD_INDEX_BITS  thread to stall
- in_block_cycles  in  BLOCK_CYCLES_WIDTH  stall length in cycles; 0 = no effect
- in_fetch_ready  in  1  fetch stage accepts the offered thread this cycle
- out_issue_valid  out  1  out_thread_index holds a pending issue
- out_thread_index  out  THREAD_INDEX_BITS  thread offered to fetch and PC array
- out_increment_flag  out  1  issue fires this cycle; PC of out_thread_index increments at the next edge

## Operation
- Per-thread stall counter cnt[i], BLOCK_CYCLES_WIDTH bits.
  - On in_block_valid with in_block_cycles != 0: cnt[idx] is loaded with in_block_cycles, overwriting any value.
  - Otherwise a nonzero cnt[i] decrements by 1 per edge and saturates at 0. A load wins over a decrement.
- Eligibility, combinational, per cycle: elig[i] = in_thread_enable_mask[i] & (cnt[i] == 0) & ~(in_block_valid & in_block_thread_index == i & in_block_cycles != 0).
- fire = out_issue_valid & in_fetch_ready. out_increment_flag = fire, combinational. This is the only non-registered output.
- Output register update at each edge:
  - Loads only when out_issue_valid == 0 or fire == 1.
  - Otherwise out_issue_valid and out_thread_index hold unchanged (backpressure).
- Selection when loading:
  - Search elig starting at last_grant+1, wrapping modulo N, and checking last_grant itself last.
  - First hit: out_thread_index <= hit, out_issue_valid <= 1, last_grant <= hit.
  - No hit: out_issue_valid <= 0, out_thread_index and last_grant unchanged.
- A sole eligible thread may be reissued back-to-back every cycle.
- A pending (held) issue is never withdrawn. If its thread is disabled or blocked while held, it still fires when in_fetch_ready rises. The block or disable takes effect for subsequent selections only.
- At most one issue per cycle. out_increment_flag is never high for two consecutive cycles on the same held entry, because a fire always reloads the register.

## Timing
- Reset (reset = 0) values: out_issue_valid = 0, out_thread_index = 0, out_increment_flag = 0, all cnt = 0, last_grant = N-1, so the first search starts at thread 0.
- Issue latency: eligibility is evaluated in cycle t; the offer is visible in cycle t+1.
- With all threads enabled and in_fetch_ready held high, the first edge after reset release presents thread 0. Threads 0..N-1 then repeat, one per cycle.
- Block timing: in_block with C != 0 in cycle t.
  - The thread is ineligible in cycle t.
  - cnt = C during t+1, reaching 0 in cycle t+C+1.
  - Earliest re-offer is cycle t+C+2.
- Async reset mid-operation: outputs go to their reset values without waiting for a clock edge. A fire in flight is lost. The downstream PC array is reset alongside.

## Test plan
- Reset release, mask = 8'hFF, ready = 1 -> out_thread_index 0,1,…,7,0 on consecutive cycles from cycle 1; out_increment_flag = 1 every cycle.
- Ready low while thread 3 is offered, for 4 cycles -> index 3 with valid = 1 held and increment_flag = 0 throughout; ready high -> one fire of thread 3, then thread 4 on the next cycle.
- mask = 8'b0010_0100 -> sequence 2,5,2,5; mask = 8'b0000_0100 -> thread 2 every cycle.
- All enabled; in cycle t, block thread 1 with C = 3 -> thread 1 is absent from the rotation until cycle t+5 and re-offered at its next round-robin turn.
- mask = 0 or all threads blocked -> valid = 0 and increment_flag = 0. Assert reset mid-stream -> all outputs zero immediately, before any edge.
- Block the currently held thread 6 while ready = 0 -> thread 6 remains offered and fires on ready; it is not reselected until its counter reaches 0.
